// File: rtl/actor_pkg.sv
// Shared types for the maze actor motion controller: one-hot direction
// encoding, direction helpers and the frame-update FSM states.
package actor_pkg;

   // One-hot direction: up, down, left, right = bits 3..0; zero means "none".
   typedef logic [3:0] dir_t;

   localparam dir_t DIR_NONE  = 4'b0000;
   localparam dir_t DIR_UP    = 4'b1000;
   localparam dir_t DIR_DOWN  = 4'b0100;
   localparam dir_t DIR_LEFT  = 4'b0010;
   localparam dir_t DIR_RIGHT = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_PROBE_TURN  = 2'd1,
      ST_PROBE_AHEAD = 2'd2,
      ST_MOVE        = 2'd3
   } state_t;

   function automatic dir_t reverse_dir(input dir_t d);
      dir_t r;
      case (d)
         DIR_UP:    r = DIR_DOWN;
         DIR_DOWN:  r = DIR_UP;
         DIR_LEFT:  r = DIR_RIGHT;
         DIR_RIGHT: r = DIR_LEFT;
         default:   r = DIR_NONE;
      endcase
      return r;
   endfunction

   function automatic logic is_onehot(input logic [3:0] v);
      return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/actor_probe_addr.sv
// Wall-probe address generator: the point PROBE pixels ahead of the actor
// centre in the given direction, modulo 2^POS_W on both axes.
module actor_probe_addr
   import actor_pkg::*;
#(
   parameter int POS_W = 10,
   parameter int PROBE = 7
)(
   input  logic [POS_W-1:0] pos_x,
   input  logic [POS_W-1:0] pos_y,
   input  logic [3:0]       dir,
   output logic [POS_W-1:0] probe_x,
   output logic [POS_W-1:0] probe_y
);

   localparam logic [POS_W-1:0] OFS = POS_W'(PROBE);

   always_comb begin
      probe_x = pos_x;
      probe_y = pos_y;
      case (dir)
         DIR_UP:    probe_y = pos_y - OFS;
         DIR_DOWN:  probe_y = pos_y + OFS;
         DIR_LEFT:  probe_x = pos_x - OFS;
         DIR_RIGHT: probe_x = pos_x + OFS;
         default:   ;
      endcase
   end

endmodule

// File: rtl/actor_motion_ctrl.sv
// Frame-stepped maze actor mover: buffered turn arbitration, wall probing over a
// valid/ack port and tunnel wrap. Optional ACTOR_CORNER_SNAP_EN snaps on turns.
module actor_motion_ctrl
   import actor_pkg::*;
#(
   parameter int         POS_W      = 10,
   parameter int         TILE_LOG2  = 4,
   parameter int         CROSS_WIN  = 2,
   parameter int         STEP       = 1,
   parameter int         PROBE      = 7,
   parameter int         START_X    = 136,
   parameter int         START_Y    = 232,
   parameter logic [3:0] START_DIR  = 4'b0001,
   parameter int         WRAP_X_MIN = 0,
   parameter int         WRAP_X_MAX = 447
)(
   input  logic             Clk,
   input  logic             Reset,
   input  logic             frame_tick,
   input  logic [3:0]       req_dir,
   output logic             probe_valid,
   output logic [POS_W-1:0] probe_x,
   output logic [POS_W-1:0] probe_y,
   input  logic             probe_ack,
   input  logic             probe_wall,
   output logic [POS_W-1:0] pos_x,
   output logic [POS_W-1:0] pos_y,
   output logic [3:0]       dir,
   output logic             moving,
   output logic             crossing,
   output logic             frame_done,
   output logic             overrun
);

   localparam int                   CENTRE     = 2 ** (TILE_LOG2 - 1);
   localparam logic [TILE_LOG2-1:0] CENTRE_LO  = TILE_LOG2'(CENTRE);
   localparam logic [TILE_LOG2-1:0] WIN_LO     = TILE_LOG2'(CENTRE - CROSS_WIN);
   localparam logic [TILE_LOG2-1:0] WIN_HI     = TILE_LOG2'(CENTRE + CROSS_WIN);
   localparam logic [POS_W-1:0]     STEP_V     = POS_W'(STEP);
   localparam logic [POS_W-1:0]     WRAP_MIN_V = POS_W'(WRAP_X_MIN);
   localparam logic [POS_W-1:0]     WRAP_MAX_V = POS_W'(WRAP_X_MAX);
   localparam logic [POS_W:0]       LEFT_LIM   = (POS_W + 1)'(WRAP_X_MIN + STEP);
   localparam logic [POS_W:0]       RIGHT_LIM  = (POS_W + 1)'(WRAP_X_MAX);

   state_t           state_q, state_d;
   logic [POS_W-1:0] pos_x_q, pos_x_d;
   logic [POS_W-1:0] pos_y_q, pos_y_d;
   dir_t             dir_q, dir_d;
   dir_t             pend_q, pend_d;
   logic             blocked_q, blocked_d;
   logic             moving_q, moving_d;
   logic             frame_done_q, frame_done_d;
   logic             overrun_q, overrun_d;
   logic             probe_valid_q, probe_valid_d;
   logic [POS_W-1:0] probe_x_q, probe_x_d;
   logic [POS_W-1:0] probe_y_q, probe_y_d;

   logic             probe_launch;
   logic             probe_release;
   dir_t             probe_dir;
   logic [POS_W-1:0] addr_x, addr_y;
   logic [TILE_LOG2-1:0] x_lo, y_lo;

   assign x_lo     = pos_x_q[TILE_LOG2-1:0];
   assign y_lo     = pos_y_q[TILE_LOG2-1:0];
   assign crossing = (x_lo >= WIN_LO) && (x_lo <= WIN_HI) &&
                     (y_lo >= WIN_LO) && (y_lo <= WIN_HI);

   // Frame sequencing. Probe addresses are taken from the *next* position and
   // direction, so the ahead probe after an accepted turn already uses them.
   always_comb begin
      state_d       = state_q;
      pos_x_d       = pos_x_q;
      pos_y_d       = pos_y_q;
      dir_d         = dir_q;
      pend_d        = pend_q;
      blocked_d     = blocked_q;
      moving_d      = moving_q;
      frame_done_d  = 1'b0;
      overrun_d     = overrun_q;
      probe_launch  = 1'b0;
      probe_release = 1'b0;
      probe_dir     = dir_q;

      case (state_q)
         ST_IDLE: begin
            if (frame_tick) begin
               probe_launch = 1'b1;
               if ((pend_q != DIR_NONE) && (pend_q == reverse_dir(dir_q))) begin
                  dir_d     = pend_q;
                  pend_d    = DIR_NONE;
                  probe_dir = pend_q;
                  state_d   = ST_PROBE_AHEAD;
               end else if ((pend_q != DIR_NONE) && (pend_q != dir_q) && crossing) begin
                  probe_dir = pend_q;
                  state_d   = ST_PROBE_TURN;
               end else begin
                  if (pend_q == dir_q) begin
                     pend_d = DIR_NONE;
                  end
                  state_d = ST_PROBE_AHEAD;
               end
            end
         end

         ST_PROBE_TURN: begin
            if (probe_ack) begin
               probe_launch = 1'b1;
               state_d      = ST_PROBE_AHEAD;
               if (!probe_wall) begin
                  dir_d     = pend_q;
                  pend_d    = DIR_NONE;
                  probe_dir = pend_q;
`ifdef ACTOR_CORNER_SNAP_EN
                  if ((pend_q == DIR_UP) || (pend_q == DIR_DOWN)) begin
                     pos_x_d[TILE_LOG2-1:0] = CENTRE_LO;
                  end else begin
                     pos_y_d[TILE_LOG2-1:0] = CENTRE_LO;
                  end
`endif
               end
            end
         end

         ST_PROBE_AHEAD: begin
            if (probe_ack) begin
               probe_release = 1'b1;
               blocked_d     = probe_wall;
               state_d       = ST_MOVE;
            end
         end

         ST_MOVE: begin
            moving_d = !blocked_q;
            if (!blocked_q) begin
               case (dir_q)
                  DIR_UP:    pos_y_d = pos_y_q - STEP_V;
                  DIR_DOWN:  pos_y_d = pos_y_q + STEP_V;
                  DIR_LEFT:  pos_x_d = ({1'b0, pos_x_q} < LEFT_LIM) ?
                                       WRAP_MAX_V : (pos_x_q - STEP_V);
                  DIR_RIGHT: pos_x_d = (({1'b0, pos_x_q} + {1'b0, STEP_V}) > RIGHT_LIM) ?
                                       WRAP_MIN_V : (pos_x_q + STEP_V);
                  default:   ;
               endcase
            end
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase

      if (frame_tick && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      // A fresh request always wins over consumption in the same cycle.
      if (is_onehot(req_dir)) begin
         pend_d = req_dir;
      end
   end

   actor_probe_addr #(
      .POS_W (POS_W),
      .PROBE (PROBE)
   ) u_probe_addr (
      .pos_x   (pos_x_d),
      .pos_y   (pos_y_d),
      .dir     (probe_dir),
      .probe_x (addr_x),
      .probe_y (addr_y)
   );

   // Probe port: valid and address are held until ack. A turn probe answered
   // without a wall is followed back-to-back by the ahead probe.
   always_comb begin
      probe_valid_d = probe_valid_q;
      probe_x_d     = probe_x_q;
      probe_y_d     = probe_y_q;
      if (probe_launch) begin
         probe_valid_d = 1'b1;
         probe_x_d     = addr_x;
         probe_y_d     = addr_y;
      end else if (probe_release) begin
         probe_valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         pos_x_q       <= POS_W'(START_X);
         pos_y_q       <= POS_W'(START_Y);
         dir_q         <= START_DIR;
         pend_q        <= DIR_NONE;
         blocked_q     <= 1'b0;
         moving_q      <= 1'b0;
         frame_done_q  <= 1'b0;
         overrun_q     <= 1'b0;
         probe_valid_q <= 1'b0;
         probe_x_q     <= '0;
         probe_y_q     <= '0;
      end else begin
         state_q       <= state_d;
         pos_x_q       <= pos_x_d;
         pos_y_q       <= pos_y_d;
         dir_q         <= dir_d;
         pend_q        <= pend_d;
         blocked_q     <= blocked_d;
         moving_q      <= moving_d;
         frame_done_q  <= frame_done_d;
         overrun_q     <= overrun_d;
         probe_valid_q <= probe_valid_d;
         probe_x_q     <= probe_x_d;
         probe_y_q     <= probe_y_d;
      end
   end

   assign probe_valid = probe_valid_q;
   assign probe_x     = probe_x_q;
   assign probe_y     = probe_y_q;
   assign pos_x       = pos_x_q;
   assign pos_y       = pos_y_q;
   assign dir         = dir_q;
   assign moving      = moving_q;
   assign frame_done  = frame_done_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_actor_motion_ctrl.sv
// Bench for actor_motion_ctrl: a reference model predicts each frame's result,
// pushes it to exp_q and compares when frame_done pulses.
module tb_actor_motion_ctrl;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_tick;
   logic [3:0] req_dir;
   logic       probe_valid;
   logic [9:0] probe_x, probe_y;
   logic       probe_ack, probe_wall;
   logic [9:0] pos_x, pos_y;
   logic [3:0] dir;
   logic       moving, crossing, frame_done, overrun;

   int total = 0;
   int bad   = 0;

   logic [24:0] exp_q[$];

   logic [9:0] m_x, m_y;
   logic [3:0] m_dir, m_pend;

   actor_motion_ctrl dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .frame_tick  (frame_tick),
      .req_dir     (req_dir),
      .probe_valid (probe_valid),
      .probe_x     (probe_x),
      .probe_y     (probe_y),
      .probe_ack   (probe_ack),
      .probe_wall  (probe_wall),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .dir         (dir),
      .moving      (moving),
      .crossing    (crossing),
      .frame_done  (frame_done),
      .overrun     (overrun)
   );

   always #5 Clk = ~Clk;

   function automatic logic [3:0] rev4(input logic [3:0] d);
      case (d)
         4'b1000: return 4'b0100;
         4'b0100: return 4'b1000;
         4'b0010: return 4'b0001;
         4'b0001: return 4'b0010;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic cross_m(input logic [9:0] x, input logic [9:0] y);
      int xl, yl;
      xl = int'(x) % 16;
      yl = int'(y) % 16;
      return (xl >= 6) && (xl <= 10) && (yl >= 6) && (yl <= 10);
   endfunction

   function automatic logic [19:0] probe_pt(input logic [9:0] x, input logic [9:0] y,
                                            input logic [3:0] d);
      logic [9:0] px, py;
      px = x;
      py = y;
      case (d)
         4'b1000: py = y - 10'd7;
         4'b0100: py = y + 10'd7;
         4'b0010: px = x - 10'd7;
         4'b0001: px = x + 10'd7;
         default: ;
      endcase
      return {px, py};
   endfunction

   task automatic model_reset();
      m_x    = 10'd136;
      m_y    = 10'd232;
      m_dir  = 4'b0001;
      m_pend = 4'b0000;
   endtask

   task automatic drive_req(input logic [3:0] v);
      req_dir = v;
      @(posedge Clk); #1;
      req_dir = 4'b0000;
      if ($countones(v) == 1) m_pend = v;
   endtask

   // One full frame: predict, push, drive tick, answer probes, pop and compare.
   task automatic run_frame(input logic wall_turn, input logic wall_ahead,
                            input int delay, input bit extra_tick);
      logic [19:0] tp, ap;
      logic [24:0] want, got;
      bit          turn, seen;
      int          cyc;
      turn = 0;
      tp   = '0;
      if ((m_pend != 0) && (m_pend == rev4(m_dir))) begin
         m_dir  = m_pend;
         m_pend = 4'b0000;
      end else if ((m_pend != 0) && (m_pend != m_dir) && cross_m(m_x, m_y)) begin
         turn = 1;
         tp   = probe_pt(m_x, m_y, m_pend);
         if (!wall_turn) begin
            m_dir  = m_pend;
            m_pend = 4'b0000;
`ifdef ACTOR_CORNER_SNAP_EN
            if (m_dir[3] || m_dir[2]) m_x[3:0] = 4'd8;
            else m_y[3:0] = 4'd8;
`endif
         end
      end else if (m_pend == m_dir) begin
         m_pend = 4'b0000;
      end
      ap = probe_pt(m_x, m_y, m_dir);
      if (!wall_ahead) begin
         case (m_dir)
            4'b1000: m_y = m_y - 10'd1;
            4'b0100: m_y = m_y + 10'd1;
            4'b0010: m_x = (m_x < 10'd1) ? 10'd447 : m_x - 10'd1;
            4'b0001: m_x = (m_x + 10'd1 > 10'd447) ? 10'd0 : m_x + 10'd1;
            default: ;
         endcase
      end
      exp_q.push_back({m_x, m_y, m_dir, !wall_ahead});

      frame_tick = 1'b1;
      @(posedge Clk); #1;
      frame_tick = 1'b0;
      cyc = 1;
      if (turn) begin
         total++;
         if ({probe_valid, probe_x, probe_y} !== {1'b1, tp}) begin
            bad++;
            $display("FAIL turn_probe: got v=%0d (%0d,%0d) want v=1 (%0d,%0d)",
                     probe_valid, probe_x, probe_y, tp[19:10], tp[9:0]);
         end
         probe_ack  = 1'b1;
         probe_wall = wall_turn;
         @(posedge Clk); #1;
         probe_ack = 1'b0;
         cyc++;
      end
      total++;
      if ({probe_valid, probe_x, probe_y} !== {1'b1, ap}) begin
         bad++;
         $display("FAIL ahead_probe: got v=%0d (%0d,%0d) want v=1 (%0d,%0d)",
                  probe_valid, probe_x, probe_y, ap[19:10], ap[9:0]);
      end
      for (int i = 0; i < delay; i++) begin
         if (extra_tick && (i == 0)) frame_tick = 1'b1;
         @(posedge Clk); #1;
         frame_tick = 1'b0;
         cyc++;
         total++;
         if ({probe_valid, probe_x, probe_y} !== {1'b1, ap}) begin
            bad++;
            $display("FAIL probe_hold: got v=%0d (%0d,%0d) want v=1 (%0d,%0d)",
                     probe_valid, probe_x, probe_y, ap[19:10], ap[9:0]);
         end
      end
      probe_ack  = 1'b1;
      probe_wall = wall_ahead;
      @(posedge Clk); #1;
      probe_ack = 1'b0;
      cyc++;
      total++;
      if (probe_valid !== 1'b0) begin
         bad++;
         $display("FAIL probe_drop: got %0d want 0", probe_valid);
      end

      seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (frame_done === 1'b1) begin
            seen = 1;
            break;
         end
         @(posedge Clk); #1;
         cyc++;
      end
      want = exp_q.pop_front();
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL frame_done_timeout: got no frame_done want pulse");
      end else begin
         got = {pos_x, pos_y, dir, moving};
         if (cyc != 3 + int'(turn) + delay) begin
            bad++;
            $display("FAIL latency: got %0d want %0d", cyc, 3 + int'(turn) + delay);
         end
         total++;
         if (got !== want) begin
            bad++;
            $display("FAIL frame_result: got (%0d,%0d) dir=%b mv=%0d want (%0d,%0d) dir=%b mv=%0d",
                     got[24:15], got[14:5], got[4:1], got[0],
                     want[24:15], want[14:5], want[4:1], want[0]);
         end
         total++;
         if (crossing !== cross_m(m_x, m_y)) begin
            bad++;
            $display("FAIL crossing: got %0d want %0d", crossing, cross_m(m_x, m_y));
         end
      end
      @(posedge Clk); #1;
      total++;
      if (frame_done !== 1'b0) begin
         bad++;
         $display("FAIL frame_done_pulse: got %0d want 0", frame_done);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      model_reset();
      total++;
      if ({pos_x, pos_y, dir, moving, probe_valid, frame_done, overrun, crossing} !==
          {10'd136, 10'd232, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL reset_state: got (%0d,%0d) dir=%b mv=%0d pv=%0d fd=%0d ov=%0d cr=%0d want (136,232) dir=0001 0 0 0 0 1",
                  pos_x, pos_y, dir, moving, probe_valid, frame_done, overrun, crossing);
      end
      Reset = 1'b0;
      @(posedge Clk); #1;
   endtask

   task automatic test_basic_move();
      run_frame(1'b0, 1'b0, 0, 1'b0);
      total++;
      if (pos_x !== 10'd137) begin
         bad++;
         $display("FAIL basic_pos_x: got %0d want 137", pos_x);
      end
   endtask

   task automatic test_reverse();
      run_frame(1'b0, 1'b0, 0, 1'b0);
      run_frame(1'b0, 1'b0, 0, 1'b0);
      drive_req(4'b0010);
      run_frame(1'b0, 1'b0, 0, 1'b0);
      run_frame(1'b0, 1'b0, 0, 1'b0);
      total++;
      if ({pos_x, dir} !== {10'd137, 4'b0010}) begin
         bad++;
         $display("FAIL reverse: got x=%0d dir=%b want x=137 dir=0010", pos_x, dir);
      end
   endtask

   task automatic test_turn();
      run_frame(1'b0, 1'b0, 0, 1'b0);
      drive_req(4'b1000);
      run_frame(1'b1, 1'b0, 0, 1'b0);
      run_frame(1'b0, 1'b0, 0, 1'b0);
      total++;
      if (dir !== 4'b1000) begin
         bad++;
         $display("FAIL turn_taken: got dir=%b want 1000", dir);
      end
   endtask

   task automatic test_wall_delay();
      run_frame(1'b0, 1'b1, 5, 1'b0);
      total++;
      if (moving !== 1'b0) begin
         bad++;
         $display("FAIL blocked_moving: got %0d want 0", moving);
      end
   endtask

   task automatic test_random();
      logic [3:0] pick [6];
      pick[0] = 4'b0001; pick[1] = 4'b0010; pick[2] = 4'b0100;
      pick[3] = 4'b1000; pick[4] = 4'b0011; pick[5] = 4'b1100;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 2) != 0) drive_req(pick[$urandom_range(0, 5)]);
         run_frame(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 3)), 1'b0);
      end
   endtask

   task automatic test_overrun();
      run_frame(1'b0, 1'b0, 2, 1'b1);
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_set: got %0d want 1", overrun);
      end
      run_frame(1'b0, 1'b0, 0, 1'b0);
      total++;
      if (overrun !== 1'b1) begin
         bad++;
         $display("FAIL overrun_sticky: got %0d want 1", overrun);
      end
   endtask

   task automatic test_reset_mid_probe();
      bit seen;
      frame_tick = 1'b1;
      @(posedge Clk); #1;
      frame_tick = 1'b0;
      Reset = 1'b1;
      @(posedge Clk); #1;
      Reset = 1'b0;
      model_reset();
      total++;
      if ({probe_valid, pos_x, pos_y, overrun} !== {1'b0, 10'd136, 10'd232, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid_probe: got pv=%0d (%0d,%0d) ov=%0d want pv=0 (136,232) ov=0",
                  probe_valid, pos_x, pos_y, overrun);
      end
      probe_ack  = 1'b1;
      probe_wall = 1'b0;
      @(posedge Clk); #1;
      probe_ack = 1'b0;
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         if (frame_done || probe_valid) seen = 1;
         @(posedge Clk); #1;
      end
      total++;
      if (seen) begin
         bad++;
         $display("FAIL late_ack: got activity want none");
      end
   endtask

   task automatic test_wrap();
      while (m_x != 10'd447) run_frame(1'b0, 1'b0, 0, 1'b0);
      run_frame(1'b0, 1'b0, 0, 1'b0);
      total++;
      if (pos_x !== 10'd0) begin
         bad++;
         $display("FAIL wrap_right: got %0d want 0", pos_x);
      end
      drive_req(4'b0010);
      run_frame(1'b0, 1'b0, 0, 1'b0);
      total++;
      if (pos_x !== 10'd447) begin
         bad++;
         $display("FAIL wrap_left: got %0d want 447", pos_x);
      end
   endtask

   initial begin
      Reset      = 1'b1;
      frame_tick = 1'b0;
      req_dir    = 4'b0000;
      probe_ack  = 1'b0;
      probe_wall = 1'b0;
      model_reset();
      @(posedge Clk); #1;
      test_reset();
      test_basic_move();
      test_reverse();
      test_turn();
      test_wall_delay();
      test_random();
      test_overrun();
      test_reset_mid_probe();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
